// File: rtl/multi_fwd_decode_stage_pkg.sv
// rtl/multi_fwd_decode_stage_pkg.sv - shared constants, forwarding, pipeline status and instruction types

package constants;
  localparam logic [31:0] RESET_ADDRESS   = 32'h0000_1000;
  localparam int          MAX_FWD         = 4;
  localparam int          DEFAULT_NUM_FWD = 2;
endpackage

package forwarding;
  typedef struct packed {
    logic [4:0]  address;
    logic        data_valid;
    logic [31:0] data;
  } t;
endpackage

package pipeline_status;
  typedef enum logic [2:0] {
    VALID, BUBBLE, ECALL, EBREAK, ILLEGAL_INSTRUCTION
  } forwards_t;

  typedef enum logic [1:0] {
    READY, STALL, JUMP
  } backwards_t;
endpackage

package instruction;
  typedef enum logic [2:0] {
    ADD, SUB, ADDI, ECALL, EBREAK, ILLEGAL
  } op_t;

  typedef struct packed {
    op_t         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } t;

  localparam t NOP = '{op: ADDI, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, imm: 32'd0};
endpackage

// File: rtl/instruction_decoder.sv
// rtl/instruction_decoder.sv - RV32 subset decoder producing instruction::t

module instruction_decoder (
  input  logic [31:0]   instruction_in,
  output instruction::t instruction_out
);
  always_comb begin
    instruction_out    = instruction::NOP;
    instruction_out.op = instruction::ILLEGAL;
    case (instruction_in[6:0])
      7'b0110011: begin
        if (instruction_in[14:12] == 3'b000 &&
            (instruction_in[31:25] == 7'b0000000 || instruction_in[31:25] == 7'b0100000)) begin
          instruction_out.op  = instruction_in[30] ? instruction::SUB : instruction::ADD;
          instruction_out.rd  = instruction_in[11:7];
          instruction_out.rs1 = instruction_in[19:15];
          instruction_out.rs2 = instruction_in[24:20];
        end
      end
      7'b0010011: begin
        if (instruction_in[14:12] == 3'b000) begin
          instruction_out.op  = instruction::ADDI;
          instruction_out.rd  = instruction_in[11:7];
          instruction_out.rs1 = instruction_in[19:15];
          instruction_out.imm = {{20{instruction_in[31]}}, instruction_in[31:20]};
        end
      end
      7'b1110011: begin
        if (instruction_in == 32'h0000_0073)      instruction_out.op = instruction::ECALL;
        else if (instruction_in == 32'h0010_0073) instruction_out.op = instruction::EBREAK;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/multi_fwd_decode_stage_operand_resolver.sv
// rtl/multi_fwd_decode_stage_operand_resolver.sv - one operand: youngest matching source wins

module operand_resolver #(
  parameter int NUM_FWD = constants::DEFAULT_NUM_FWD
) (
  input  logic [4:0]                 address_in,
  input  logic [31:0]                rf_data_in,
  input  forwarding::t [NUM_FWD-1:0] fwd_in,
  input  forwarding::t               wb_in,
  output logic [31:0]                data_out,
  output logic                       hazard_out
);
  logic matched;

  always_comb begin
    data_out   = rf_data_in;
    hazard_out = 1'b0;
    matched    = 1'b0;
    if (address_in == 5'd0) begin
      data_out = 32'd0;
    end else begin
      // An unready match blocks all older sources, so stop at the first hit.
      for (int i = 0; i < NUM_FWD; i++) begin
        if (!matched && fwd_in[i].address == address_in) begin
          matched    = 1'b1;
          hazard_out = !fwd_in[i].data_valid;
          if (fwd_in[i].data_valid) data_out = fwd_in[i].data;
        end
      end
      if (!matched && wb_in.address == address_in) begin
        hazard_out = !wb_in.data_valid;
        if (wb_in.data_valid) data_out = wb_in.data;
      end
    end
  end
endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - 32x32 register file, two async read ports, write from write-back

module register_file (
  input  logic         clk,
  input  logic         rst,
  input  logic [4:0]   rs1_address_in,
  input  logic [4:0]   rs2_address_in,
  output logic [31:0]  rs1_data_out,
  output logic [31:0]  rs2_data_out,
  input  forwarding::t wb_in
);
  logic [31:0] regs_q [32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
    end else if (wb_in.data_valid && wb_in.address != 5'd0) begin
      regs_q[wb_in.address] <= wb_in.data;
    end
  end

  assign rs1_data_out = regs_q[rs1_address_in];
  assign rs2_data_out = regs_q[rs2_address_in];
endmodule

// File: rtl/multi_fwd_decode_stage.sv
// rtl/multi_fwd_decode_stage.sv - decode stage with N-source forwarding; DECODE_STALL_COUNT_EN adds a hazard-bubble counter

module multi_fwd_decode_stage #(
  parameter int          NUM_FWD  = constants::DEFAULT_NUM_FWD,
  parameter logic [31:0] RESET_PC = constants::RESET_ADDRESS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 instruction_in,
  input  logic [31:0]                 program_counter_in,
  input  forwarding::t [NUM_FWD-1:0]  fwd_in,
  input  forwarding::t                wb_forwarding_in,
  output logic [31:0]                 rs1_data_reg_out,
  output logic [31:0]                 rs2_data_reg_out,
  output logic [31:0]                 program_counter_reg_out,
  output instruction::t               instruction_reg_out,
  input  pipeline_status::forwards_t  status_forwards_in,
  output pipeline_status::forwards_t  status_forwards_out,
  input  pipeline_status::backwards_t status_backwards_in,
  output pipeline_status::backwards_t status_backwards_out,
  input  logic [31:0]                 jump_address_backwards_in,
  output logic [31:0]                 jump_address_backwards_out
`ifdef DECODE_STALL_COUNT_EN
  ,
  output logic [31:0]                 stall_count_out
`endif
);
  instruction::t              decoded, instr_q, instr_d;
  pipeline_status::forwards_t status_q, status_d;
  logic [31:0] pc_q, pc_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [31:0] rf_rs1, rf_rs2, rs1_res, rs2_res;
  logic        rs1_hazard, rs2_hazard, hazard_stall;

  instruction_decoder u_decoder (.instruction_in(instruction_in), .instruction_out(decoded));

  register_file u_regfile (
    .clk(clk), .rst(rst),
    .rs1_address_in(decoded.rs1), .rs2_address_in(decoded.rs2),
    .rs1_data_out(rf_rs1), .rs2_data_out(rf_rs2),
    .wb_in(wb_forwarding_in)
  );

  operand_resolver #(.NUM_FWD(NUM_FWD)) u_rs1 (
    .address_in(decoded.rs1), .rf_data_in(rf_rs1), .fwd_in(fwd_in),
    .wb_in(wb_forwarding_in), .data_out(rs1_res), .hazard_out(rs1_hazard)
  );

  operand_resolver #(.NUM_FWD(NUM_FWD)) u_rs2 (
    .address_in(decoded.rs2), .rf_data_in(rf_rs2), .fwd_in(fwd_in),
    .wb_in(wb_forwarding_in), .data_out(rs2_res), .hazard_out(rs2_hazard)
  );

  assign hazard_stall = rs1_hazard | rs2_hazard;
  assign status_backwards_out = (hazard_stall && status_backwards_in == pipeline_status::READY)
                                ? pipeline_status::STALL : status_backwards_in;
  assign jump_address_backwards_out = jump_address_backwards_in;

  always_comb begin
    instr_d  = instr_q;
    pc_d     = pc_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    status_d = status_q;
    if (status_forwards_in != pipeline_status::VALID) begin
      instr_d  = decoded;
      pc_d     = program_counter_in;
      status_d = status_forwards_in;
    end else if (status_backwards_in == pipeline_status::READY) begin
      if (hazard_stall) begin
        instr_d  = instruction::NOP;
        status_d = pipeline_status::BUBBLE;
      end else begin
        instr_d = decoded;
        pc_d    = program_counter_in;
        rs1_d   = rs1_res;
        rs2_d   = rs2_res;
        case (decoded.op)
          instruction::ECALL:   status_d = pipeline_status::ECALL;
          instruction::EBREAK:  status_d = pipeline_status::EBREAK;
          instruction::ILLEGAL: status_d = pipeline_status::ILLEGAL_INSTRUCTION;
          default:              status_d = pipeline_status::VALID;
        endcase
      end
    end else if (status_backwards_in == pipeline_status::JUMP) begin
      // Squashed by a taken jump: keep the fields but mark as bubble.
      instr_d  = decoded;
      pc_d     = program_counter_in;
      rs1_d    = rs1_res;
      rs2_d    = rs2_res;
      status_d = pipeline_status::BUBBLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q  <= instruction::NOP;
      pc_q     <= RESET_PC;
      rs1_q    <= 32'd0;
      rs2_q    <= 32'd0;
      status_q <= pipeline_status::BUBBLE;
    end else begin
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      status_q <= status_d;
    end
  end

  assign instruction_reg_out     = instr_q;
  assign program_counter_reg_out = pc_q;
  assign rs1_data_reg_out        = rs1_q;
  assign rs2_data_reg_out        = rs2_q;
  assign status_forwards_out     = status_q;

`ifdef DECODE_STALL_COUNT_EN
  logic [31:0] stall_count_q;
  logic        bubble_load;

  assign bubble_load = status_forwards_in == pipeline_status::VALID &&
                       status_backwards_in == pipeline_status::READY && hazard_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        stall_count_q <= 32'd0;
    else if (bubble_load && stall_count_q != '1)    stall_count_q <= stall_count_q + 32'd1;
  end

  assign stall_count_out = stall_count_q;
`endif
endmodule
